// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// The optional match counter is controlled by the MATCH_COUNT_EN macro in the top module.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;

    // Width needed to hold a pattern length in the range 0..max.
    function automatic int len_w(input int max);
        return $clog2(max + 1);
    endfunction

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

endpackage

// File: rtl/seq_det_mask_cmp.sv
// Masked equality of the sampled window {hist,w} against the pattern, looking only
// at the low len bits; an out-of-range length never matches.
module seq_det_mask_cmp
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LW      = len_w(DEF_MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] window,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LW-1:0]      len,
    output logic               eq
);

    logic [MAX_LEN-1:0] mask;
    logic               len_ok;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len)) begin
                mask[i] = 1'b1;
            end
        end
        len_ok = (len != '0) && (int'(len) <= MAX_LEN);
        eq     = len_ok && (((window ^ pat) & mask) == '0);
    end

endmodule

// File: rtl/seq_detector_mealy_param.sv
// Programmable Mealy serial-pattern detector with overlap control and sample enable.
// Define MATCH_COUNT_EN to build the saturating match counter; otherwise match_cnt reads 0.
module seq_detector_mealy_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        en,
    input  logic                        w,
    input  logic [MAX_LEN-1:0]          pat,
    input  logic [len_w(MAX_LEN)-1:0]   len,
    input  logic                        ovl,
    input  logic                        cnt_clr,
    output logic                        z,
    output logic                        z_q,
    output logic [CNT_W-1:0]            match_cnt
);

    localparam int            LW       = len_w(MAX_LEN);
    localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN - 1);

    logic [MAX_LEN-2:0] hist;
    logic [LW-1:0]      fill;
    logic [MAX_LEN-1:0] window;
    logic               pat_eq;
    logic               fill_ok;
    mode_e              mode;

    assign window = {hist, w};
    assign mode   = mode_e'(ovl);

    seq_det_mask_cmp #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_cmp (
        .window (window),
        .pat    (pat),
        .len    (len),
        .eq     (pat_eq)
    );

    // A match needs len-1 valid history bits plus the bit currently on w.
    assign fill_ok = ({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len};
    assign z       = en && pat_eq && fill_ok;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hist <= '0;
            fill <= '0;
            z_q  <= 1'b0;
        end else begin
            z_q <= z;
            if (en) begin
                hist <= window[MAX_LEN-2:0];
                // Non-overlapping mode forgets the history so the next match needs fresh bits.
                if (z && (mode == MODE_NONOVL)) begin
                    fill <= '0;
                end else if (fill != FILL_MAX) begin
                    fill <= fill + LW'(1);
                end
            end
        end
    end

`ifdef MATCH_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge Clk) begin
        if (Reset || cnt_clr) begin
            match_cnt <= '0;
        end else if (z && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_mealy_param.sv
// Self-checking bench for seq_detector_mealy_param: directed scenarios plus random
// traffic, all checked against a queue-based reference model of the detector.
module tb_seq_detector_mealy_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = 4;
    localparam int CNT_SAT = 3;

    logic               Clk;
    logic               Reset;
    logic               en;
    logic               w;
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic               ovl;
    logic               cnt_clr;
    logic               z;
    logic               z_q;
    logic [CNT_W-1:0]   match_cnt;

    int   assertCount = 0;
    int   failCount   = 0;
    int   zHits       = 0;

    // Reference model: every sampled bit plus how many are "fresh" since reset or last non-overlap match.
    bit   sampled[$];
    int   fresh  = 0;
    logic expZq  = 1'b0;
    int   expCnt = 0;

    seq_detector_mealy_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .en        (en),
        .w         (w),
        .pat       (pat),
        .len       (len),
        .ovl       (ovl),
        .cnt_clr   (cnt_clr),
        .z         (z),
        .z_q       (z_q),
        .match_cnt (match_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic modelZ();
        logic b;
        if (!en) return 1'b0;
        if (len == 0 || int'(len) > MAX_LEN) return 1'b0;
        if (fresh < int'(len) - 1) return 1'b0;
        for (int k = 0; k < int'(len); k++) begin
            b = (k == 0) ? w : logic'(sampled[sampled.size() - k]);
            if (b !== pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic enI, input logic wI, input logic rstI, input logic clrI);
        logic ez;
        int   expCntOut;
        @(negedge Clk);
        en      = enI;
        w       = wI;
        Reset   = rstI;
        cnt_clr = clrI;
        #1;
        ez = modelZ();
        checkOutput("z", {31'b0, z}, {31'b0, ez});
        if (z === 1'b1) zHits++;
        @(posedge Clk);
        if (rstI) begin
            sampled.delete();
            fresh  = 0;
            expZq  = 1'b0;
            expCnt = 0;
        end else begin
            expZq = ez;
            if (enI) begin
                sampled.push_back(wI);
                if (sampled.size() > 16) sampled = sampled[1:$];
                if (ez && !ovl) fresh = 0;
                else if (fresh < 16) fresh++;
            end
            if (clrI) expCnt = 0;
            else if (ez && expCnt < CNT_SAT) expCnt++;
        end
`ifdef MATCH_COUNT_EN
        expCntOut = expCnt;
`else
        expCntOut = 0;
`endif
        #1;
        checkOutput("z_q", {31'b0, z_q}, {31'b0, expZq});
        checkOutput("match_cnt", 32'(match_cnt), 32'(expCntOut));
    endtask

    task automatic sendBits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b1, bits[i], 1'b0, 1'b0);
        end
    endtask

    task automatic pulseReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        zHits = 0;
    endtask

    initial begin
        en = 1'b0; w = 1'b0; Reset = 1'b1; cnt_clr = 1'b0;
        pat = 8'b101; len = 4'd3; ovl = 1'b1;

        pulseReset();
        checkOutput("reset_zq", {31'b0, z_q}, 32'd0);
        checkOutput("reset_cnt", 32'(match_cnt), 32'd0);

        // Overlapping 101 on 1,0,1,1,0,1,0,1.
        sendBits(16'b1011_0101, 8);
        checkOutput("t1_hits", 32'(zHits), 32'd3);

        // Same stream, non-overlapping.
        ovl = 1'b0;
        pulseReset();
        sendBits(16'b1011_0101, 8);
        checkOutput("t2_hits", 32'(zHits), 32'd2);

        // Full-width pattern 0xA5 twice.
        pat = 8'hA5; len = 4'd8; ovl = 1'b1;
        pulseReset();
        sendBits(16'hA5A5, 16);
        checkOutput("t3_hits", 32'(zHits), 32'd2);

        // Idle cycles with w toggling between bits 2 and 3.
        pat = 8'b101; len = 4'd3;
        pulseReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_hits", 32'(zHits), 32'd1);

        // Reset after 1,0 wipes the partial match.
        pulseReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        pulseReset();
        checkOutput("t5_zq", {31'b0, z_q}, 32'd0);
        checkOutput("t5_cnt", 32'(match_cnt), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_hits", 32'(zHits), 32'd0);

        // Counter saturation, then clear coinciding with a match.
        pat = 8'h01; len = 4'd1;
        pulseReset();
        sendBits(16'b1_1111, 5);
        checkOutput("t6_hits", 32'(zHits), 32'd5);
`ifdef MATCH_COUNT_EN
        checkOutput("t6_sat", 32'(match_cnt), 32'd3);
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_clr", 32'(match_cnt), 32'd0);

        // Random traffic with periodic reconfiguration under reset.
        for (int blk = 0; blk < 12; blk++) begin
            pat = MAX_LEN'($urandom);
            if ($urandom_range(0, 5) == 0) len = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd9;
            else len = LW'($urandom_range(1, 5));
            ovl = 1'($urandom);
            pulseReset();
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 19) == 0) ovl = ~ovl;
                applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom),
                              1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 15) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
